battle_sequencer: RTL

BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

---
 rtl/battle_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/battle_sequencer.sv
// battle_sequencer: frame-paced turn sequencer for the battle screen.
// Button and hit events are captured between frames and acted on once per vsync-derived tick.
module battle_sequencer #(
    parameter int PLAYER_HP     = 100,
    parameter int ENEMY_HP      = 100,
    parameter int DODGE_FRAMES  = 300,
    parameter int HIT_DAMAGE    = 10,
    parameter int INVULN_FRAMES = 30,
    parameter int SLIDER_STEP   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        btn_confirm,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        hit,
    output logic [31:0] state,
    output logic        mercy
);
    typedef enum logic [3:0] {
        TITLE  = 4'b0001,
        ACT    = 4'b1011,
        CHECK  = 4'b1100,
        ATTACK = 4'b1010,
        DODGE  = 4'b1001,
        OVER   = 4'b0000
    } mode_t;

    localparam logic [7:0]  P_HP      = 8'(PLAYER_HP);
    localparam logic [7:0]  E_HP      = 8'(ENEMY_HP);
    localparam logic [7:0]  MERCY_HP  = 8'(ENEMY_HP / 4);
    localparam logic [7:0]  HIT_DMG   = 8'(HIT_DAMAGE);
    localparam logic [15:0] DODGE_LEN = 16'(DODGE_FRAMES);
    localparam logic [15:0] INV_LEN   = 16'(INVULN_FRAMES);
    localparam logic [8:0]  STEP      = 9'(SLIDER_STEP);

    mode_t       mode, mode_n;
    logic [7:0]  php, php_n, ehp, ehp_n, slider, slider_n;
    logic [15:0] dodge_cnt, dodge_cnt_n, inv, inv_n;
    logic        mercy_n;
    logic        armed, vsync_q, tick;
    logic [2:0]  btn, btn_q, rise, pend, pend_n;
    logic        hit_pend, hit_pend_n;
    logic        confirm, lr, take_hit;
    logic [8:0]  adv, d;
    logic [7:0]  dmg, ehp_hit, php_hit;

    // armed masks edges seen right after reset release (vsync or a button already high)
    assign btn      = {btn_confirm, btn_left, btn_right};
    assign rise     = armed ? (btn & ~btn_q) : 3'b000;
    assign confirm  = pend[2];
    assign lr       = pend[1] ^ pend[0];
    assign take_hit = hit_pend && inv == 16'd0;
    assign adv      = {1'b0, slider} + STEP;
    assign d        = slider[7] ? {1'b0, slider} - 9'd128 : 9'd128 - {1'b0, slider};
    assign dmg      = d <= 9'd16 ? 8'd20 : d <= 9'd64 ? 8'd10 : 8'd0;
    assign ehp_hit  = ehp > dmg ? ehp - dmg : 8'd0;
    assign php_hit  = php > HIT_DMG ? php - HIT_DMG : 8'd0;

    always_comb begin
        mode_n      = mode;
        php_n       = php;
        ehp_n       = ehp;
        slider_n    = slider;
        dodge_cnt_n = dodge_cnt;
        inv_n       = inv;
        mercy_n     = mercy;
        pend_n      = tick ? rise : (pend | rise);
        if (tick) begin
            case (mode)
                TITLE: if (confirm) begin
                    mode_n  = ACT;
                    php_n   = P_HP;
                    ehp_n   = E_HP;
                    mercy_n = 1'b0;
                end
                ACT: if (confirm) begin
                    mode_n   = ATTACK;
                    slider_n = 8'd0;
                end else if (lr) mode_n = CHECK;
                CHECK: if (confirm) begin
                    mode_n  = ACT;
                    mercy_n = ehp <= MERCY_HP;
                end else if (lr) mode_n = ACT;
                ATTACK: if (confirm || slider == 8'hff) begin
                    ehp_n       = ehp_hit;
                    mode_n      = ehp_hit == 8'd0 ? TITLE : DODGE;
                    dodge_cnt_n = 16'd0;
                end else slider_n = adv[8] ? 8'hff : adv[7:0];
                DODGE: begin
                    php_n       = take_hit ? php_hit : php;
                    inv_n       = take_hit ? INV_LEN : (inv != 16'd0 ? inv - 16'd1 : 16'd0);
                    dodge_cnt_n = dodge_cnt + 16'd1;
                    if (php_n == 8'd0) mode_n = OVER;
                    else if (dodge_cnt_n >= DODGE_LEN) mode_n = ACT;
                end
                OVER: if (confirm) mode_n = TITLE;
                default: mode_n = TITLE;
            endcase
        end
        // slider is only meaningful (and displayed) in ATTACK/DODGE; invuln only lives inside DODGE
        slider_n   = (mode_n == ATTACK || mode_n == DODGE) ? slider_n : 8'd0;
        inv_n      = mode_n == DODGE ? inv_n : 16'd0;
        hit_pend_n = mode == DODGE && mode_n == DODGE && (hit || (hit_pend && !tick));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode      <= TITLE;
            php       <= P_HP;
            ehp       <= E_HP;
            slider    <= 8'd0;
            dodge_cnt <= 16'd0;
            inv       <= 16'd0;
            mercy     <= 1'b0;
            armed     <= 1'b0;
            vsync_q   <= 1'b0;
            tick      <= 1'b0;
            btn_q     <= 3'b000;
            pend      <= 3'b000;
            hit_pend  <= 1'b0;
        end else begin
            mode      <= mode_n;
            php       <= php_n;
            ehp       <= ehp_n;
            slider    <= slider_n;
            dodge_cnt <= dodge_cnt_n;
            inv       <= inv_n;
            mercy     <= mercy_n;
            armed     <= 1'b1;
            vsync_q   <= vsync;
            tick      <= armed & vsync & ~vsync_q;
            btn_q     <= btn;
            pend      <= pend_n;
            hit_pend  <= hit_pend_n;
        end
    end

    assign state = {mode, 4'b0000, ehp, php, slider};
endmodule
